// File: rtl/ctrl_reg_bank_if.sv
// User-side register access strobes between the AXI-Lite slave front end and the register bank.
interface ctrl_reg_bank_if #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned DATA_BYTES = DATA_BITS / 8
);
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [DATA_BITS-1:0]  wr_dout;
  logic [DATA_BYTES-1:0] wr_be;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  rd_en;
  logic [DATA_BITS-1:0]  rd_din;
  logic                  rd_ready;

  modport master (
    output wr_addr, wr_dout, wr_be, wr_en, rd_addr, rd_en,
    input  rd_din, rd_ready
  );

  modport slave (
    input  wr_addr, wr_dout, wr_be, wr_en, rd_addr, rd_en,
    output rd_din, rd_ready
  );
endinterface

// File: rtl/ctrl_reg_bank.sv
// Control/status register bank: ID, CTRL, STATUS, W1C interrupt status/enable, scratch,
// free-running cycle timer with compare; single-cycle read response.
module ctrl_reg_bank #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned DATA_BYTES = DATA_BITS / 8,
  parameter logic [31:0] ID_VALUE   = 32'h7E5A_0001
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  ctrl_reg_bank_if.slave         bus,
  input  logic [15:0]            status_in,
  input  logic [6:0]             irq_src,
  output logic                   ctrl_enable,
  output logic [7:0]             ctrl_mode,
  output logic                   ctrl_soft_rst,
  output logic                   irq
);

  localparam logic [5:0] OffId     = 6'h00;
  localparam logic [5:0] OffCtrl   = 6'h01;
  localparam logic [5:0] OffStatus = 6'h02;
  localparam logic [5:0] OffIrqSt  = 6'h03;
  localparam logic [5:0] OffIrqEn  = 6'h04;
  localparam logic [5:0] OffScr    = 6'h05;
  localparam logic [5:0] OffTimer  = 6'h06;
  localparam logic [5:0] OffCmp    = 6'h07;

  function automatic logic [31:0] apply_be(logic [31:0] old, logic [31:0] wdata,
                                           logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  logic        enable_q, enable_d;
  logic [7:0]  mode_q, mode_d;
  logic        soft_rst_q, soft_rst_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  irq_en_q, irq_en_d;
  logic [7:0]  irq_st_q, irq_st_d;
  logic [6:0]  src_hist_q, src_hist_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_ready_q;
  logic        irq_q, irq_d;

  logic [5:0]  wr_sel, rd_sel;
  logic [31:0] wdata, ctrl_word, ctrl_new, rd_mux;
  logic [3:0]  be;
  logic [7:0]  irq_set, w1c;
  logic        match;

  logic unused_addr;
  assign unused_addr = ^{bus.wr_addr[ADDR_BITS-1:8], bus.wr_addr[1:0],
                         bus.rd_addr[ADDR_BITS-1:8], bus.rd_addr[1:0]};

  assign wr_sel    = bus.wr_addr[7:2];
  assign rd_sel    = bus.rd_addr[7:2];
  assign wdata     = bus.wr_dout[31:0];
  assign be        = bus.wr_be[3:0];
  assign ctrl_word = {16'h0, mode_q, 7'h0, enable_q};

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    scratch_d  = scratch_q;
    cmp_d      = cmp_q;
    irq_en_d   = irq_en_q;
    soft_rst_d = 1'b0;
    w1c        = 8'h0;
    ctrl_new   = apply_be(ctrl_word, wdata, be);

    if (bus.wr_en) begin
      unique case (wr_sel)
        OffCtrl: begin
          enable_d   = ctrl_new[0];
          mode_d     = ctrl_new[15:8];
          soft_rst_d = be[0] & wdata[1];
        end
        OffIrqSt: w1c       = wdata[7:0] & {8{be[0]}};
        OffIrqEn: irq_en_d  = apply_be({24'h0, irq_en_q}, wdata, be) & 32'hFF;
        OffScr:   scratch_d = apply_be(scratch_q, wdata, be);
        OffCmp:   cmp_d     = apply_be(cmp_q, wdata, be);
        default:  ;
      endcase
    end

    match   = enable_q && (timer_q == cmp_q);
    irq_set = {match, irq_src & ~src_hist_q};

    // Soft reset overrides counting and interrupt capture on the same edge.
    if (soft_rst_d) begin
      timer_d    = 32'h0;
      irq_st_d   = 8'h0;
      src_hist_d = 7'h0;
    end else begin
      timer_d    = enable_q ? timer_q + 32'd1 : timer_q;
      irq_st_d   = (irq_st_q & ~w1c) | irq_set;
      src_hist_d = irq_src;
    end

    irq_d = |(irq_st_q & irq_en_q);

    rd_mux = 32'h0;
    unique case (rd_sel)
      OffId:     rd_mux = ID_VALUE;
      OffCtrl:   rd_mux = ctrl_word;
      OffStatus: rd_mux = {16'h0, status_in};
      OffIrqSt:  rd_mux = {24'h0, irq_st_q};
      OffIrqEn:  rd_mux = {24'h0, irq_en_q};
      OffScr:    rd_mux = scratch_q;
      OffTimer:  rd_mux = timer_q;
      OffCmp:    rd_mux = cmp_q;
      default:   rd_mux = 32'h0;
    endcase
    rd_data_d = bus.rd_en ? rd_mux : rd_data_q;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      enable_q   <= 1'b0;
      mode_q     <= 8'h0;
      soft_rst_q <= 1'b0;
      scratch_q  <= 32'h0;
      cmp_q      <= 32'h0;
      timer_q    <= 32'h0;
      irq_en_q   <= 8'h0;
      irq_st_q   <= 8'h0;
      src_hist_q <= 7'h0;
      rd_data_q  <= 32'h0;
      rd_ready_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      soft_rst_q <= soft_rst_d;
      scratch_q  <= scratch_d;
      cmp_q      <= cmp_d;
      timer_q    <= timer_d;
      irq_en_q   <= irq_en_d;
      irq_st_q   <= irq_st_d;
      src_hist_q <= src_hist_d;
      rd_data_q  <= rd_data_d;
      rd_ready_q <= bus.rd_en;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_din     = rd_data_q;
  assign bus.rd_ready   = rd_ready_q;
  assign ctrl_enable    = enable_q;
  assign ctrl_mode      = mode_q;
  assign ctrl_soft_rst  = soft_rst_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Self-checking bench for ctrl_reg_bank: read expectations queued at strobe time, popped on rd_ready.
module tb_ctrl_reg_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] status_in;
  logic [6:0]  irq_src;
  logic        ctrl_enable;
  logic [7:0]  ctrl_mode;
  logic        ctrl_soft_rst;
  logic        irq;

  always #5 clk = ~clk;

  ctrl_reg_bank_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

  ctrl_reg_bank #(
    .ADDR_BITS (32),
    .DATA_BITS (32),
    .ID_VALUE  (32'h7E5A_0001)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .bus           (bus.slave),
    .status_in     (status_in),
    .irq_src       (irq_src),
    .ctrl_enable   (ctrl_enable),
    .ctrl_mode     (ctrl_mode),
    .ctrl_soft_rst (ctrl_soft_rst),
    .irq           (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rd_ready must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_spurious", {31'h0, bus.rd_ready}, 32'h0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check_eq(e.tag, bus.rd_din, e.exp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_addr = a;
    bus.wr_dout = d;
    bus.wr_be   = be;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    bus.rd_en   = 1'b1;
    exp_q.push_back('{tag, exp});
    @(negedge clk);
    check_eq({tag, "_rdy"}, {31'h0, bus.rd_ready}, 32'h1);
    bus.rd_en   = 1'b0;
  endtask

  task automatic wr_rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp);
    bus.wr_addr = a;
    bus.wr_dout = d;
    bus.wr_be   = be;
    bus.wr_en   = 1'b1;
    bus.rd_addr = a;
    bus.rd_en   = 1'b1;
    exp_q.push_back('{tag, exp});
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    status_in   = 16'hBEEF;
    irq_src     = 7'h0;
    bus.wr_addr = '0;
    bus.wr_dout = '0;
    bus.wr_be   = '0;
    bus.wr_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_en   = 1'b0;
    cycles(2);
    // Strobes during reset must be dropped.
    bus.wr_addr = 32'h14;
    bus.wr_dout = 32'hDEAD_BEEF;
    bus.wr_be   = 4'hF;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    cycles(1);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    rst         = 1'b0;
    check_eq("rst_outs", {20'h0, ctrl_mode, ctrl_enable, ctrl_soft_rst, irq, bus.rd_ready},
             32'h0);
    check_eq("rst_rd_din", bus.rd_din, 32'h0);

    reg_rd("id", 32'h00, 32'h7E5A_0001);
    reg_rd("ctrl_rst", 32'h04, 32'h0);
    reg_rd("unmapped", 32'h40, 32'h0);
    reg_rd("scr_rst", 32'h14, 32'h0);
    reg_rd("status", 32'h08, 32'h0000_BEEF);
    reg_rd("id_alias", 32'h103, 32'h7E5A_0001);

    reg_wr(32'h14, 32'hA5A5_A5A5, 4'hF);
    wr_rd("scr_same_cyc", 32'h14, 32'h1122_3344, 4'b0101, 32'hA5A5_A5A5);
    reg_rd("scr_be", 32'h14, 32'hA522_A544);

    reg_wr(32'h1C, 32'd20, 4'hF);
    reg_wr(32'h10, 32'hFFFF_FF80, 4'hF);
    reg_wr(32'h04, 32'h0000_0301, 4'hF);
    check_eq("ctrl_mode", {24'h0, ctrl_mode}, 32'h3);
    check_eq("ctrl_enable", {31'h0, ctrl_enable}, 32'h1);
    wait_irq(n);
    check_eq("tmr_irq_lat", n, 32'd22);
    reg_rd("irqst_tmr", 32'h0C, 32'h80);
    reg_rd("irqen_mask", 32'h10, 32'h80);
    reg_wr(32'h0C, 32'h80, 4'b1110);
    cycles(1);
    check_eq("w1c_be_off", {31'h0, irq}, 32'h1);
    reg_wr(32'h0C, 32'h80, 4'hF);
    cycles(1);
    check_eq("irq_drop", {31'h0, irq}, 32'h0);

    irq_src = 7'h04;
    cycles(3);
    irq_src = 7'h00;
    cycles(1);
    reg_rd("edge", 32'h0C, 32'h04);
    reg_wr(32'h0C, 32'h04, 4'hF);
    reg_rd("edge_clr", 32'h0C, 32'h0);
    irq_src = 7'h04;
    cycles(2);
    reg_rd("edge_held", 32'h0C, 32'h04);
    reg_wr(32'h0C, 32'h04, 4'hF);
    cycles(3);
    reg_rd("held_no_reset", 32'h0C, 32'h0);
    irq_src = 7'h00;
    cycles(1);
    irq_src = 7'h04;
    reg_wr(32'h0C, 32'h04, 4'hF);
    reg_rd("set_wins", 32'h0C, 32'h04);
    irq_src = 7'h00;
    cycles(2);

    reg_wr(32'h04, 32'h0000_0003, 4'hF);
    check_eq("srst_pulse", {31'h0, ctrl_soft_rst}, 32'h1);
    reg_rd("tmr_srst", 32'h18, 32'h0);
    check_eq("srst_one_cyc", {31'h0, ctrl_soft_rst}, 32'h0);
    reg_rd("irqst_srst", 32'h0C, 32'h0);
    reg_rd("ctrl_srst", 32'h04, 32'h1);
    reg_rd("scr_srst", 32'h14, 32'hA522_A544);
    reg_rd("irqen_srst", 32'h10, 32'h80);
    reg_rd("cmp_srst", 32'h1C, 32'd20);

    reg_wr(32'h04, 32'h0, 4'hF);
    reg_wr(32'h1C, 32'h0, 4'hF);
    reg_wr(32'h0C, 32'hFF, 4'hF);
    force dut.timer_q = 32'hFFFF_FFFE;
    cycles(1);
    release dut.timer_q;
    reg_rd("tmr_forced", 32'h18, 32'hFFFF_FFFE);
    reg_wr(32'h04, 32'h1, 4'hF);
    wait_irq(n);
    check_eq("wrap_irq_lat", n, 32'd4);
    reg_rd("irqst_wrap", 32'h0C, 32'h80);

    cycles(2);
    check_eq("rd_pending", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
